// File: rtl/trap_ctrl.sv
// Trap sequencer and single-port CSR write arbiter for the machine-mode CSR file.
// Traps and mret take the write port for a fixed mepc/mcause/mstatus sequence,
// then flush and redirect. Idle cycles pass pipeline CSR writes straight through.
module trap_ctrl #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        irq_ext_i,
    input  logic        irq_timer_i,
    input  logic        irq_soft_i,
    input  logic [31:0] mstatus_i,
    input  logic [31:0] mie_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    input  logic        instr_valid_i,
    input  logic [31:0] pc_i,
    input  logic        is_mret_i,
    input  logic        pipe_csr_wr_req_i,
    input  logic [11:0] pipe_csr_addr_i,
    input  logic [31:0] pipe_csr_wdata_i,
    output logic        pipe_csr_ready_o,
    output logic        csr_wr_req_o,
    output logic [11:0] csr_addr_o,
    output logic [31:0] csr_wdata_o,
    output logic [31:0] mip_o,
    output logic        pipe_stall_o,
    output logic        flush_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        busy_o
);

    // Fewer than two synchroniser flops is never safe; clamp instead of failing.
    localparam int unsigned SYNC_N   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned CODE_W   = 5;
    localparam int unsigned STATE_W  = 3;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    localparam logic [CODE_W-1:0] CODE_SOFT  = 5'd3;
    localparam logic [CODE_W-1:0] CODE_TIMER = 5'd7;
    localparam logic [CODE_W-1:0] CODE_EXT   = 5'd11;

    localparam logic [STATE_W-1:0] S_IDLE        = 3'd0;
    localparam logic [STATE_W-1:0] S_SAVE_EPC    = 3'd1;
    localparam logic [STATE_W-1:0] S_SAVE_CAUSE  = 3'd2;
    localparam logic [STATE_W-1:0] S_SAVE_STATUS = 3'd3;
    localparam logic [STATE_W-1:0] S_REDIRECT    = 3'd4;
    localparam logic [STATE_W-1:0] S_MRET_STATUS = 3'd5;

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;

    logic [SYNC_N-1:0]  ext_sync_q;
    logic               ext_synced;

    logic [XLEN-1:0]    cap_pc_q;
    logic [CODE_W-1:0]  cap_code_q;
    logic [XLEN-1:0]    cap_mstatus_q;
    logic [XLEN-1:0]    cap_mepc_q;
    logic               cap_mret_q;

    logic               ext_en;
    logic               soft_en;
    logic               timer_en;
    logic               irq_any;
    logic [CODE_W-1:0]  irq_code;
    logic               is_idle;
    logic               take_trap;
    logic               take_mret;

    logic [XLEN-1:0]    trap_mstatus;
    logic [XLEN-1:0]    mret_mstatus;
    logic [XLEN-1:0]    tvec_base;
    logic [XLEN-1:0]    tvec_target;

    logic               unused_bits;

    // Only the three architected interrupt enables are consulted.
    assign unused_bits = ^{mie_i[31:12], mie_i[10:8], mie_i[6:4], mie_i[2:0]};

    // External interrupt is asynchronous: shift it through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_sync_q <= '0;
        end else begin
            ext_sync_q <= {ext_sync_q[SYNC_N-2:0], irq_ext_i};
        end
    end

    assign ext_synced = ext_sync_q[SYNC_N-1];

    // Interrupt enable masking and fixed priority ext > soft > timer.
    always_comb begin
        ext_en   = ext_synced  & mie_i[11];
        soft_en  = irq_soft_i  & mie_i[3];
        timer_en = irq_timer_i & mie_i[7];
        irq_any  = ext_en | soft_en | timer_en;
        irq_code = '0;
        if (ext_en) begin
            irq_code = CODE_EXT;
        end else if (soft_en) begin
            irq_code = CODE_SOFT;
        end else if (timer_en) begin
            irq_code = CODE_TIMER;
        end
    end

    // Take decisions; held off while reset is asserted so every output stays quiet.
    assign is_idle   = (state_q == S_IDLE);
    assign take_trap = rst_n & is_idle & instr_valid_i & mstatus_i[3] & irq_any;
    assign take_mret = rst_n & is_idle & instr_valid_i & is_mret_i & ~take_trap;

    // Latch the faulting context on the detection cycle so later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_pc_q      <= '0;
            cap_code_q    <= '0;
            cap_mstatus_q <= '0;
            cap_mepc_q    <= '0;
            cap_mret_q    <= 1'b0;
        end else if (take_trap || take_mret) begin
            cap_pc_q      <= pc_i;
            cap_code_q    <= take_trap ? irq_code : '0;
            cap_mstatus_q <= mstatus_i;
            cap_mepc_q    <= take_mret ? mepc_i : cap_mepc_q;
            cap_mret_q    <= take_mret;
        end
    end

    // New mstatus images for trap entry and mret, plus the trap vector target.
    always_comb begin
        trap_mstatus        = cap_mstatus_q;
        trap_mstatus[7]     = cap_mstatus_q[3];
        trap_mstatus[3]     = 1'b0;
        trap_mstatus[12:11] = 2'b11;

        mret_mstatus        = cap_mstatus_q;
        mret_mstatus[3]     = cap_mstatus_q[7];
        mret_mstatus[7]     = 1'b1;
        mret_mstatus[12:11] = 2'b11;

        tvec_base = {mtvec_i[31:2], 2'b00};
        if (mtvec_i[1:0] == 2'b01) begin
            tvec_target = tvec_base + (XLEN'(cap_code_q) << 2);
        end else begin
            tvec_target = tvec_base;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and CSR port / pipeline control decode.
    always_comb begin
        state_d          = state_q;
        csr_wr_req_o     = 1'b0;
        csr_addr_o       = '0;
        csr_wdata_o      = '0;
        pipe_csr_ready_o = 1'b0;
        flush_o          = 1'b0;
        redirect_o       = 1'b0;
        redirect_pc_o    = '0;

        case (state_q)
            S_IDLE: begin
                if (take_trap) begin
                    state_d = S_SAVE_EPC;
                end else if (take_mret) begin
                    state_d = S_MRET_STATUS;
                end else if (rst_n) begin
                    csr_wr_req_o     = pipe_csr_wr_req_i;
                    csr_addr_o       = pipe_csr_addr_i;
                    csr_wdata_o      = pipe_csr_wdata_i;
                    pipe_csr_ready_o = 1'b1;
                end
            end
            S_SAVE_EPC: begin
                csr_wr_req_o = 1'b1;
                csr_addr_o   = ADDR_MEPC;
                csr_wdata_o  = {cap_pc_q[31:2], 2'b00};
                state_d      = S_SAVE_CAUSE;
            end
            S_SAVE_CAUSE: begin
                csr_wr_req_o = 1'b1;
                csr_addr_o   = ADDR_MCAUSE;
                csr_wdata_o  = {1'b1, 26'b0, cap_code_q};
                state_d      = S_SAVE_STATUS;
            end
            S_SAVE_STATUS: begin
                csr_wr_req_o = 1'b1;
                csr_addr_o   = ADDR_MSTATUS;
                csr_wdata_o  = trap_mstatus;
                state_d      = S_REDIRECT;
            end
            S_MRET_STATUS: begin
                csr_wr_req_o = 1'b1;
                csr_addr_o   = ADDR_MSTATUS;
                csr_wdata_o  = mret_mstatus;
                state_d      = S_REDIRECT;
            end
            S_REDIRECT: begin
                flush_o       = 1'b1;
                redirect_o    = 1'b1;
                redirect_pc_o = cap_mret_q ? cap_mepc_q : tvec_target;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pipeline hold covers the detection cycle as well as the whole sequence.
    assign busy_o       = ~is_idle;
    assign pipe_stall_o = take_trap | take_mret | ~is_idle;

    // Pending view: synced external, raw timer and software lines.
    assign mip_o = rst_n ? {20'b0, ext_synced, 3'b0, irq_timer_i, 3'b0, irq_soft_i, 3'b0}
                         : '0;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: reset, pass-through, trap entry, vectored ext trap,
// mret, trap/mret/pipe-write collision and reset in the middle of a sequence.
module tb_trap_ctrl;

    logic        clk;
    logic        rst_n;
    logic        irq_ext_i;
    logic        irq_timer_i;
    logic        irq_soft_i;
    logic [31:0] mstatus_i;
    logic [31:0] mie_i;
    logic [31:0] mtvec_i;
    logic [31:0] mepc_i;
    logic        instr_valid_i;
    logic [31:0] pc_i;
    logic        is_mret_i;
    logic        pipe_csr_wr_req_i;
    logic [11:0] pipe_csr_addr_i;
    logic [31:0] pipe_csr_wdata_i;
    logic        pipe_csr_ready_o;
    logic        csr_wr_req_o;
    logic [11:0] csr_addr_o;
    logic [31:0] csr_wdata_o;
    logic [31:0] mip_o;
    logic        pipe_stall_o;
    logic        flush_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    trap_ctrl #(.SYNC_STAGES(2)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .irq_ext_i         (irq_ext_i),
        .irq_timer_i       (irq_timer_i),
        .irq_soft_i        (irq_soft_i),
        .mstatus_i         (mstatus_i),
        .mie_i             (mie_i),
        .mtvec_i           (mtvec_i),
        .mepc_i            (mepc_i),
        .instr_valid_i     (instr_valid_i),
        .pc_i              (pc_i),
        .is_mret_i         (is_mret_i),
        .pipe_csr_wr_req_i (pipe_csr_wr_req_i),
        .pipe_csr_addr_i   (pipe_csr_addr_i),
        .pipe_csr_wdata_i  (pipe_csr_wdata_i),
        .pipe_csr_ready_o  (pipe_csr_ready_o),
        .csr_wr_req_o      (csr_wr_req_o),
        .csr_addr_o        (csr_addr_o),
        .csr_wdata_o       (csr_wdata_o),
        .mip_o             (mip_o),
        .pipe_stall_o      (pipe_stall_o),
        .flush_o           (flush_o),
        .redirect_o        (redirect_o),
        .redirect_pc_o     (redirect_pc_o),
        .busy_o            (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_write(input string tag, input logic [11:0] addr, input logic [31:0] data);
        chk({tag, "_req"},   32'(csr_wr_req_o), 32'd1);
        chk({tag, "_addr"},  32'(csr_addr_o),   32'(addr));
        chk({tag, "_wdata"}, csr_wdata_o,       data);
        chk({tag, "_stall"}, 32'(pipe_stall_o), 32'd1);
        chk({tag, "_ready"}, 32'(pipe_csr_ready_o), 32'd0);
    endtask

    initial begin
        rst_n             = 1'b0;
        irq_ext_i         = 1'b0;
        irq_timer_i       = 1'b0;
        irq_soft_i        = 1'b0;
        mstatus_i         = '0;
        mie_i             = '0;
        mtvec_i           = '0;
        mepc_i            = '0;
        instr_valid_i     = 1'b0;
        pc_i              = '0;
        is_mret_i         = 1'b0;
        pipe_csr_wr_req_i = 1'b1;
        pipe_csr_addr_i   = 12'h305;
        pipe_csr_wdata_i  = 32'h100;

        // Reset: outputs quiet even with a pipeline write pending
        tick();
        tick();
        chk("rst_req",    32'(csr_wr_req_o),     32'd0);
        chk("rst_ready",  32'(pipe_csr_ready_o), 32'd0);
        chk("rst_busy",   32'(busy_o),           32'd0);
        chk("rst_stall",  32'(pipe_stall_o),     32'd0);
        chk("rst_mip",    mip_o,                 32'd0);

        // Idle pass-through
        rst_n = 1'b1;
        #1;
        chk("pt_req",      32'(csr_wr_req_o),     32'd1);
        chk("pt_addr",     32'(csr_addr_o),       32'h305);
        chk("pt_wdata",    csr_wdata_o,           32'h100);
        chk("pt_ready",    32'(pipe_csr_ready_o), 32'd1);
        chk("pt_stall",    32'(pipe_stall_o),     32'd0);
        chk("pt_flush",    32'(flush_o),          32'd0);
        chk("pt_redirect", 32'(redirect_o),       32'd0);
        chk("pt_busy",     32'(busy_o),           32'd0);
        chk("pt_mip",      mip_o,                 32'd0);
        pipe_csr_wr_req_i = 1'b0;

        // Timer trap, direct mode
        tick();
        mstatus_i     = 32'h8;
        mie_i         = 32'h80;
        mtvec_i       = 32'h100;
        irq_timer_i   = 1'b1;
        pc_i          = 32'h1000;
        instr_valid_i = 1'b1;
        #1;
        chk("tt_T_stall", 32'(pipe_stall_o),     32'd1);
        chk("tt_T_ready", 32'(pipe_csr_ready_o), 32'd0);
        chk("tt_T_busy",  32'(busy_o),           32'd0);
        chk("tt_T_mip",   mip_o,                 32'h80);
        tick();
        instr_valid_i = 1'b0;
        irq_timer_i   = 1'b0;
        pc_i          = 32'hDEAD_BEE0;
        #1;
        chk_write("tt_epc", 12'h341, 32'h1000);
        chk("tt_epc_busy", 32'(busy_o), 32'd1);
        tick();
        chk_write("tt_cause", 12'h342, 32'h8000_0007);
        tick();
        chk_write("tt_status", 12'h300, 32'h1880);
        tick();
        chk("tt_redir_req",   32'(csr_wr_req_o), 32'd0);
        chk("tt_redir_flush", 32'(flush_o),      32'd1);
        chk("tt_redir_valid", 32'(redirect_o),   32'd1);
        chk("tt_redir_pc",    redirect_pc_o,     32'h100);
        chk("tt_redir_stall", 32'(pipe_stall_o), 32'd1);
        tick();
        chk("tt_end_busy",  32'(busy_o),       32'd0);
        chk("tt_end_stall", 32'(pipe_stall_o), 32'd0);
        chk("tt_end_flush", 32'(flush_o),      32'd0);

        // External trap, vectored mode, ext visible only after the synchroniser
        mie_i       = 32'h888;
        mtvec_i     = 32'h201;
        irq_ext_i   = 1'b1;
        irq_soft_i  = 1'b1;
        irq_timer_i = 1'b1;
        #1;
        chk("ext_mip_0", mip_o, 32'h88);
        tick();
        chk("ext_mip_1", mip_o, 32'h88);
        tick();
        chk("ext_mip_2", mip_o, 32'h888);
        pc_i          = 32'h2000;
        instr_valid_i = 1'b1;
        #1;
        chk("ext_T_stall", 32'(pipe_stall_o), 32'd1);
        tick();
        instr_valid_i = 1'b0;
        irq_ext_i     = 1'b0;
        irq_soft_i    = 1'b0;
        irq_timer_i   = 1'b0;
        #1;
        chk_write("ext_epc", 12'h341, 32'h2000);
        tick();
        chk_write("ext_cause", 12'h342, 32'h8000_000B);
        tick();
        chk_write("ext_status", 12'h300, 32'h1880);
        tick();
        chk("ext_redir_valid", 32'(redirect_o), 32'd1);
        chk("ext_redir_pc",    redirect_pc_o,   32'h22C);
        tick();
        chk("ext_end_busy", 32'(busy_o), 32'd0);
        tick();
        tick();

        // mret
        mstatus_i     = 32'h1880;
        mepc_i        = 32'h1000;
        is_mret_i     = 1'b1;
        instr_valid_i = 1'b1;
        pc_i          = 32'h5000;
        #1;
        chk("mret_T_stall", 32'(pipe_stall_o), 32'd1);
        chk("mret_T_req",   32'(csr_wr_req_o), 32'd0);
        tick();
        is_mret_i     = 1'b0;
        instr_valid_i = 1'b0;
        #1;
        chk_write("mret_status", 12'h300, 32'h1888);
        tick();
        chk("mret_redir_req",   32'(csr_wr_req_o), 32'd0);
        chk("mret_redir_flush", 32'(flush_o),      32'd1);
        chk("mret_redir_valid", 32'(redirect_o),   32'd1);
        chk("mret_redir_pc",    redirect_pc_o,     32'h1000);
        tick();
        chk("mret_end_busy", 32'(busy_o), 32'd0);

        // Trap, mret and pipe write in the same cycle; mtvec mode 3 is direct
        mstatus_i         = 32'h8;
        mie_i             = 32'h80;
        mtvec_i           = 32'h103;
        irq_timer_i       = 1'b1;
        is_mret_i         = 1'b1;
        instr_valid_i     = 1'b1;
        pc_i              = 32'h3000;
        pipe_csr_wr_req_i = 1'b1;
        pipe_csr_addr_i   = 12'h304;
        pipe_csr_wdata_i  = 32'hAAAA;
        #1;
        chk("col_T_req",   32'(csr_wr_req_o),     32'd0);
        chk("col_T_ready", 32'(pipe_csr_ready_o), 32'd0);
        chk("col_T_stall", 32'(pipe_stall_o),     32'd1);
        tick();
        irq_timer_i   = 1'b0;
        is_mret_i     = 1'b0;
        instr_valid_i = 1'b0;
        #1;
        chk_write("col_epc", 12'h341, 32'h3000);
        pipe_csr_wr_req_i = 1'b0;
        tick();
        chk_write("col_cause", 12'h342, 32'h8000_0007);
        tick();
        chk_write("col_status", 12'h300, 32'h1880);
        tick();
        chk("col_redir_pc", redirect_pc_o, 32'h100);
        tick();
        chk("col_end_busy", 32'(busy_o), 32'd0);

        // Reset during SAVE_CAUSE
        irq_timer_i   = 1'b1;
        instr_valid_i = 1'b1;
        pc_i          = 32'h4000;
        tick();
        instr_valid_i = 1'b0;
        irq_timer_i   = 1'b0;
        tick();
        chk_write("rs_cause", 12'h342, 32'h8000_0007);
        rst_n             = 1'b0;
        irq_timer_i       = 1'b1;
        pipe_csr_wr_req_i = 1'b1;
        pipe_csr_addr_i   = 12'h305;
        #1;
        chk("rs_req",   32'(csr_wr_req_o),     32'd0);
        chk("rs_addr",  32'(csr_addr_o),       32'd0);
        chk("rs_busy",  32'(busy_o),           32'd0);
        chk("rs_stall", 32'(pipe_stall_o),     32'd0);
        chk("rs_ready", 32'(pipe_csr_ready_o), 32'd0);
        chk("rs_flush", 32'(flush_o),          32'd0);
        chk("rs_mip",   mip_o,                 32'd0);
        tick();
        rst_n             = 1'b1;
        irq_timer_i       = 1'b0;
        pipe_csr_wr_req_i = 1'b0;
        #1;
        chk("rs_rel_req",  32'(csr_wr_req_o), 32'd0);
        chk("rs_rel_busy", 32'(busy_o),       32'd0);
        tick();
        chk("rs_post_req",  32'(csr_wr_req_o), 32'd0);
        chk("rs_post_busy", 32'(busy_o),       32'd0);
        chk("rs_post_redir", 32'(redirect_o),  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
